// File: rtl/cfg_sram_pkg.sv
// Shared definitions for the configuration SRAM slave: register offsets and
// the byte-lane merge used by every writable register.
package cfg_sram_pkg;

    localparam logic [15:0] OFF_SCRATCH0 = 16'h8000;
    localparam logic [15:0] OFF_SCRATCH1 = 16'h8004;
    localparam logic [15:0] OFF_TIMER    = 16'he000;
    localparam logic [15:0] OFF_CMP      = 16'he004;
    localparam logic [15:0] OFF_STATUS   = 16'he008;
    localparam logic [15:0] OFF_LED      = 16'hf000;
    localparam logic [15:0] OFF_SWITCH   = 16'hf004;
    localparam logic [15:0] OFF_NUM      = 16'hf008;

    // Lane i of the result comes from new_val when wen[i] is set, else from old_val.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  wen);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = wen[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/cfg_timer.sv
// Free-running 32-bit timer with a compare register and a sticky match flag.
// Write-load ports carry values already merged with the current contents.
module cfg_timer
    import cfg_sram_pkg::*;
#(
    parameter logic [31:0] TIMER_RST = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        timer_we,
    input  logic [31:0] timer_wval,
    input  logic        cmp_we,
    input  logic [31:0] cmp_wval,
    input  logic        match_clr,
    output logic [31:0] timer_val,
    output logic [31:0] cmp_val,
    output logic        match
);

    logic [31:0] timer_q, timer_d;
    logic [31:0] cmp_q, cmp_d;
    logic        match_q, match_d;

    always_comb begin
        timer_d = timer_we ? timer_wval : timer_q + 32'd1;
        cmp_d   = cmp_we ? cmp_wval : cmp_q;
        // Compare uses the registered cmp so a CMP write counts from the next cycle;
        // a coincident set beats a W1C clear.
        match_d = match_q;
        if (timer_d == cmp_q) begin
            match_d = 1'b1;
        end else if (match_clr) begin
            match_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= TIMER_RST;
            cmp_q   <= 32'hffff_ffff;
            match_q <= 1'b0;
        end else begin
            timer_q <= timer_d;
            cmp_q   <= cmp_d;
            match_q <= match_d;
        end
    end

    assign timer_val = timer_q;
    assign cmp_val   = cmp_q;
    assign match     = match_q;

endmodule

// File: rtl/cfg_sram_slave.sv
// Memory-mapped configuration/peripheral registers presented with the timing of
// a synchronous SRAM: scratch, timer/compare/status, LED, switch input, display.
module cfg_sram_slave
    import cfg_sram_pkg::*;
#(
    parameter logic [15:0] BASE_HI        = 16'hbfaf,
    parameter int          SW_SYNC_STAGES = 2,
    parameter logic [31:0] TIMER_RST      = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sram_en,
    input  logic [3:0]  sram_wen,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    input  logic [7:0]  switch,
    output logic [15:0] led,
    output logic [31:0] num_data,
    output logic        timer_irq
);

    // Request protocol: a request is accepted in every cycle sram_en is high (no
    // backpressure). Reads (wen==0) return data on the next cycle; sram_rdata then
    // holds until the next read request.

    logic [31:0] scratch0_q, scratch0_d;
    logic [31:0] scratch1_q, scratch1_d;
    logic [15:0] led_q, led_d;
    logic [31:0] num_q, num_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  sw_q [SW_SYNC_STAGES];
    logic [7:0]  sw_d [SW_SYNC_STAGES];

    logic        hit, rd_req, wr_hit;
    logic [15:0] off;
    logic [31:0] rd_val;
    logic        timer_we, cmp_we, match_clr;
    logic [31:0] timer_wval, cmp_wval;
    logic [31:0] timer_val, cmp_val;
    logic        match;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^sram_addr[1:0];

    cfg_timer #(
        .TIMER_RST (TIMER_RST)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .timer_we   (timer_we),
        .timer_wval (timer_wval),
        .cmp_we     (cmp_we),
        .cmp_wval   (cmp_wval),
        .match_clr  (match_clr),
        .timer_val  (timer_val),
        .cmp_val    (cmp_val),
        .match      (match)
    );

    always_comb begin
        hit    = sram_en && (sram_addr[31:16] == BASE_HI);
        off    = {sram_addr[15:2], 2'b00};
        rd_req = sram_en && (sram_wen == 4'b0000);
        wr_hit = hit && (sram_wen != 4'b0000);

        case (off)
            OFF_SCRATCH0: rd_val = scratch0_q;
            OFF_SCRATCH1: rd_val = scratch1_q;
            OFF_TIMER:    rd_val = timer_val;
            OFF_CMP:      rd_val = cmp_val;
            OFF_STATUS:   rd_val = {31'h0, match};
            OFF_LED:      rd_val = {16'h0, led_q};
            OFF_SWITCH:   rd_val = {24'h0, sw_q[SW_SYNC_STAGES-1]};
            OFF_NUM:      rd_val = num_q;
            default:      rd_val = 32'h0;
        endcase

        // Misses and unmapped offsets both read as zero.
        rdata_d = rdata_q;
        if (rd_req) begin
            rdata_d = hit ? rd_val : 32'h0;
        end

        scratch0_d = scratch0_q;
        scratch1_d = scratch1_q;
        led_d      = led_q;
        num_d      = num_q;
        timer_we   = 1'b0;
        cmp_we     = 1'b0;
        match_clr  = 1'b0;
        timer_wval = merge_bytes(timer_val, sram_wdata, sram_wen);
        cmp_wval   = merge_bytes(cmp_val, sram_wdata, sram_wen);

        if (wr_hit) begin
            case (off)
                OFF_SCRATCH0: scratch0_d = merge_bytes(scratch0_q, sram_wdata, sram_wen);
                OFF_SCRATCH1: scratch1_d = merge_bytes(scratch1_q, sram_wdata, sram_wen);
                OFF_TIMER:    timer_we   = 1'b1;
                OFF_CMP:      cmp_we     = 1'b1;
                OFF_STATUS:   match_clr  = sram_wen[0] && sram_wdata[0];
                OFF_LED:      led_d      = 16'(merge_bytes({16'h0, led_q}, sram_wdata, sram_wen));
                OFF_NUM:      num_d      = merge_bytes(num_q, sram_wdata, sram_wen);
                default:      ;
            endcase
        end

        sw_d[0] = switch;
        for (int i = 1; i < SW_SYNC_STAGES; i++) begin
            sw_d[i] = sw_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scratch0_q <= 32'h0;
            scratch1_q <= 32'h0;
            led_q      <= 16'h0;
            num_q      <= 32'h0;
            rdata_q    <= 32'h0;
            for (int i = 0; i < SW_SYNC_STAGES; i++) begin
                sw_q[i] <= 8'h0;
            end
        end else begin
            scratch0_q <= scratch0_d;
            scratch1_q <= scratch1_d;
            led_q      <= led_d;
            num_q      <= num_d;
            rdata_q    <= rdata_d;
            for (int i = 0; i < SW_SYNC_STAGES; i++) begin
                sw_q[i] <= sw_d[i];
            end
        end
    end

    assign sram_rdata = rdata_q;
    assign led        = led_q;
    assign num_data   = num_q;
    assign timer_irq  = match;

endmodule

// File: tb/tb_cfg_sram_slave.sv
// Directed bench for cfg_sram_slave: bus driver tasks, a read-data scoreboard
// queue, and immediate-assertion checks on outputs.
module tb_cfg_sram_slave;

    localparam logic [31:0] BASE = 32'hbfaf_0000;
    localparam logic [31:0] MISS = 32'hbfb0_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sram_en = 1'b0;
    logic [3:0]  sram_wen = 4'h0;
    logic [31:0] sram_addr = 32'h0;
    logic [31:0] sram_wdata = 32'h0;
    logic [31:0] sram_rdata;
    logic [7:0]  switch = 8'h0;
    logic [15:0] led;
    logic [31:0] num_data;
    logic        timer_irq;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic        rd_pending = 1'b0;

    cfg_sram_slave dut (
        .clk        (clk),
        .reset      (reset),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .switch     (switch),
        .led        (led),
        .num_data   (num_data),
        .timer_irq  (timer_irq)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled 1 ns after the edge, read data scored against the queue.
    task automatic cycle();
        logic [31:0] e;
        string       t;
        @(posedge clk);
        #1;
        if (rd_pending) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, sram_rdata, e);
            rd_pending = 1'b0;
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] data);
        sram_en    = 1'b1;
        sram_wen   = wen;
        sram_addr  = addr;
        sram_wdata = data;
        cycle();
        sram_en    = 1'b0;
        sram_wen   = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        sram_en   = 1'b1;
        sram_wen  = 4'h0;
        sram_addr = addr;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        rd_pending = 1'b1;
        cycle();
        sram_en = 1'b0;
    endtask

    initial begin
        // reset
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_rdata", sram_rdata, 32'h0);
        check("rst_led", {16'h0, led}, 32'h0);
        check("rst_num", num_data, 32'h0);
        check("rst_irq", {31'h0, timer_irq}, 32'h0);

        // timer counts one per cycle from reset
        bus_read(BASE | 32'he000, 32'h0, "timer_first");
        bus_read(BASE | 32'he000, 32'h1, "timer_next");

        // byte-lane writes
        bus_write(BASE | 32'hf000, 4'b0011, 32'h1234_5678);
        check("led_lanes", {16'h0, led}, 32'h0000_5678);
        bus_read(BASE | 32'hf000, 32'h0000_5678, "led_read");
        bus_write(BASE | 32'h8000, 4'b1111, 32'h1122_3344);
        bus_write(BASE | 32'h8000, 4'b0100, 32'h00ab_0000);
        bus_read(BASE | 32'h8000, 32'h11ab_3344, "scratch0_lane2");

        // misses and unmapped offsets
        bus_read(MISS | 32'h8000, 32'h0, "miss_read");
        bus_read(BASE | 32'hf000, 32'h0000_5678, "led_reread");
        bus_read(BASE | 32'h1234, 32'h0, "unmapped_read");
        bus_write(MISS | 32'h8000, 4'b1111, 32'hffff_ffff);
        bus_write(BASE | 32'h1234, 4'b1111, 32'hffff_ffff);
        bus_write(MISS | 32'hf000, 4'b1111, 32'hffff_ffff);
        sram_en    = 1'b0;
        sram_wen   = 4'b1111;
        sram_addr  = BASE | 32'h8000;
        sram_wdata = 32'hdead_beef;
        cycle();
        sram_wen   = 4'h0;
        bus_read(BASE | 32'h8000, 32'h11ab_3344, "scratch0_after_miss");
        check("led_after_miss", {16'h0, led}, 32'h0000_5678);

        // compare/match: timer loaded 0x10, match on the 16th edge after
        bus_write(BASE | 32'he004, 4'b1111, 32'h20);
        bus_write(BASE | 32'he000, 4'b1111, 32'h10);
        for (int i = 1; i <= 16; i++) begin
            cycle();
            check($sformatf("irq_step%0d", i), {31'h0, timer_irq}, {31'h0, (i == 16)});
        end
        cycle();
        check("irq_sticky", {31'h0, timer_irq}, 32'h1);
        bus_read(BASE | 32'he008, 32'h1, "status_set");

        // clear coincident with a second match: set wins
        bus_write(BASE | 32'he000, 4'b1111, 32'h1d);
        cycle();
        cycle();
        bus_write(BASE | 32'he008, 4'b0001, 32'h1);
        check("irq_set_wins", {31'h0, timer_irq}, 32'h1);
        cycle();
        bus_write(BASE | 32'he008, 4'b0001, 32'h1);
        check("irq_cleared", {31'h0, timer_irq}, 32'h0);
        bus_read(BASE | 32'he008, 32'h0, "status_clear");

        // switch synchronizer latency
        switch = 8'ha5;
        bus_read(BASE | 32'hf004, 32'h0, "switch_lat1");
        bus_read(BASE | 32'hf004, 32'h0, "switch_lat2");
        bus_read(BASE | 32'hf004, 32'h0000_00a5, "switch_synced");

        // back-to-back reads of every register
        bus_write(BASE | 32'h8004, 4'b1111, 32'hcafe_f00d);
        bus_write(BASE | 32'hf008, 4'b1111, 32'h55);
        check("num_port", num_data, 32'h55);
        bus_read(BASE | 32'h8000, 32'h11ab_3344, "b2b_scratch0");
        bus_read(BASE | 32'h8004, 32'hcafe_f00d, "b2b_scratch1");
        bus_read(BASE | 32'hf000, 32'h0000_5678, "b2b_led");
        bus_read(BASE | 32'hf008, 32'h55, "b2b_num");
        bus_read(BASE | 32'hf004, 32'h0000_00a5, "b2b_switch");
        bus_read(BASE | 32'he004, 32'h20, "b2b_cmp");
        bus_read(BASE | 32'he00c, 32'h0, "b2b_unmapped");
        bus_read(BASE | 32'hf00a, 32'h55, "b2b_low_bits_ignored");

        // reset during an in-flight read
        sram_en   = 1'b1;
        sram_wen  = 4'h0;
        sram_addr = BASE | 32'hf008;
        reset     = 1'b1;
        exp_q.push_back(32'h0);
        tag_q.push_back("reset_inflight");
        rd_pending = 1'b1;
        cycle();
        sram_en = 1'b0;
        reset   = 1'b0;
        check("reset_num", num_data, 32'h0);
        check("reset_led", {16'h0, led}, 32'h0);
        bus_read(BASE | 32'he000, 32'h0, "reset_timer");
        bus_read(BASE | 32'h8004, 32'h0, "reset_scratch1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
